// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
//   Shared definitions for the single-bus CPU datapath:
//     - DATA_W     : datapath word width
//     - RAM_DEPTH  : words of optional internal RAM (DATAPATH_INTERNAL_RAM_EN)
//     - OP_*       : 5-bit opcodes decoded from IR[31:27]
//     - con_cond_e : branch condition encodings held in IR[20:19]
//     - con_eval() : evaluates a branch condition against a bus value
// -----------------------------------------------------------------------------
package datapath_pkg;

    localparam int DATA_W    = 32;
    localparam int RAM_DEPTH = 512;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_JAL  = 5'b10101;

    typedef enum logic [1:0] {
        COND_ZERO    = 2'b00,
        COND_NONZERO = 2'b01,
        COND_GE_ZERO = 2'b10,
        COND_LT_ZERO = 2'b11
    } con_cond_e;

    function automatic logic con_eval(con_cond_e cond, logic [DATA_W-1:0] value);
        logic result;
        case (cond)
            COND_ZERO:    result = (value == '0);
            COND_NONZERO: result = (value != '0);
            COND_GE_ZERO: result = ~value[DATA_W-1];
            default:      result = value[DATA_W-1];
        endcase
        return result;
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// -----------------------------------------------------------------------------
// datapath_alu
//   Purely combinational ALU of the single-bus datapath.
//   Ports:
//     A       in  32  first operand (Y register)
//     B       in  32  second operand (bus)
//     opcode  in  5   IR[31:27]
//     IncPC   in  1   override: result = B + 1
//     Cin     in  1   carry/borrow-in for add/sub
//     result  out 64  full result; upper half is sign extension except mul/div
// -----------------------------------------------------------------------------
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [4:0]          opcode,
    input  logic                IncPC,
    input  logic                Cin,
    output logic [2*DATA_W-1:0] result
);

    logic [4:0]          shamt;
    logic [2*DATA_W-1:0] doubled;
    logic [2*DATA_W-1:0] rol_wide;
    logic [2*DATA_W-1:0] ror_wide;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   quotient;
    logic [DATA_W-1:0]   remainder;
    logic [DATA_W-1:0]   low;

    assign shamt    = B[4:0];
    // Rotates are done by shifting the word concatenated with itself.
    assign doubled  = {A, A};
    assign ror_wide = doubled >> shamt;
    assign rol_wide = doubled << shamt;
    assign product  = $signed({{DATA_W{A[DATA_W-1]}}, A}) *
                      $signed({{DATA_W{B[DATA_W-1]}}, B});

    // Divide by zero yields quotient 0 and remainder A rather than X.
    always_comb begin
        quotient  = '0;
        remainder = A;
        if (B != '0) begin
            quotient  = $signed(A) / $signed(B);
            remainder = $signed(A) % $signed(B);
        end
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        low    = B;
        result = '0;
        if (IncPC) begin
            low = B + 1'b1;
        end else begin
            case (opcode)
                OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI, OP_JAL:
                    low = A + B + {{(DATA_W-1){1'b0}}, Cin};
                OP_SUB:        low = A - B - {{(DATA_W-1){1'b0}}, Cin};
                OP_SHR:        low = A >> shamt;
                OP_SHRA:       low = $signed(A) >>> shamt;
                OP_SHL:        low = A << shamt;
                OP_ROR:        low = ror_wide[DATA_W-1:0];
                OP_ROL:        low = rol_wide[2*DATA_W-1:DATA_W];
                OP_AND, OP_ANDI: low = A & B;
                OP_OR,  OP_ORI:  low = A | B;
                OP_NEG:        low = -B;
                OP_NOT:        low = ~B;
                default:       low = B;
            endcase
        end

        result = {{DATA_W{low[DATA_W-1]}}, low};
        if (!IncPC && opcode == OP_MUL) result = product;
        if (!IncPC && opcode == OP_DIV) result = {remainder, quotient};
    end

endmodule

// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
//   32-bit single-bus CPU datapath driven cycle by cycle by an external
//   control unit. Registers: R0-R15, PC, IR, MAR, MDR, Y, Z(64), HI, LO,
//   in-port, out-port and the CON branch flag.
//   Ports:
//     Clock, Clear            clock, asynchronous active-low reset
//     OutPort_output          out-port register contents
//     *out strobes            select the single bus driver (fixed priority)
//     *_enable / *In strobes  load the named register at the rising edge
//     Gra/Grb/Grc, R_in, R_out, BAout   register-file access via IR fields
//     IncPC, Cin              PC increment / ALU B+1 override, ALU carry-in
//     MDR_read, Mdatain       MDR source select and memory read data
//     RAM_write               write MDR to internal RAM (optional feature)
//     InPort_input            external input port data
//   Build option: define DATAPATH_INTERNAL_RAM_EN to add a RAM_DEPTH-word RAM
//   addressed by MAR; otherwise MDR_read selects Mdatain and RAM_write is
//   ignored.
// -----------------------------------------------------------------------------
module datapath
    import datapath_pkg::*;
(
    input  logic              Clock,
    input  logic              Clear,
    output logic [DATA_W-1:0] OutPort_output,
    input  logic              IncPC,
    input  logic              CONin,
    input  logic              RAM_write,
    input  logic              MDR_enable,
    input  logic              MDRout,
    input  logic              MAR_enable,
    input  logic              IR_enable,
    input  logic              MDR_read,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              Grc,
    input  logic              HI_enable,
    input  logic              LO_enable,
    input  logic              ZHighIn,
    input  logic              ZLowIn,
    input  logic              Y_enable,
    input  logic              PC_enable,
    input  logic              OutPort_enable,
    input  logic              InPortout,
    input  logic              PCout,
    input  logic              Yout,
    input  logic              ZLowout,
    input  logic              ZHighout,
    input  logic              LOout,
    input  logic              HIout,
    input  logic              BAout,
    input  logic              R_out,
    input  logic              Cout,
    input  logic              R_in,
    input  logic              Cin,
    input  logic [DATA_W-1:0] InPort_input,
    input  logic [DATA_W-1:0] Mdatain
);

    logic [DATA_W-1:0]   regs [16];
    logic [DATA_W-1:0]   pc, ir, mar, mdr, y_reg, hi, lo, in_port, out_port;
    logic [2*DATA_W-1:0] z_reg;
    logic                con;

    logic [DATA_W-1:0]   bus;
    logic [3:0]          reg_sel;
    logic [DATA_W-1:0]   c_sext;
    logic [DATA_W-1:0]   mem_data;
    logic [2*DATA_W-1:0] alu_result;

    // Register index: OR of the IR fields whose strobe is high.
    assign reg_sel = ({4{Gra}} & ir[26:23]) |
                     ({4{Grb}} & ir[22:19]) |
                     ({4{Grc}} & ir[18:15]);

    assign c_sext = {{(DATA_W-19){ir[18]}}, ir[18:0]};

    // Single shared bus, fixed priority; idle bus reads as zero.
    always_comb begin
        bus = '0;
        if (R_out)          bus = regs[reg_sel];
        else if (BAout)     bus = (reg_sel == 4'd0) ? '0 : regs[reg_sel];
        else if (HIout)     bus = hi;
        else if (LOout)     bus = lo;
        else if (ZHighout)  bus = z_reg[2*DATA_W-1:DATA_W];
        else if (ZLowout)   bus = z_reg[DATA_W-1:0];
        else if (PCout)     bus = pc;
        else if (MDRout)    bus = mdr;
        else if (InPortout) bus = in_port;
        else if (Yout)      bus = y_reg;
        else if (Cout)      bus = c_sext;
    end

    datapath_alu u_alu (
        .A      (y_reg),
        .B      (bus),
        .opcode (ir[31:27]),
        .IncPC  (IncPC),
        .Cin    (Cin),
        .result (alu_result)
    );

`ifdef DATAPATH_INTERNAL_RAM_EN
    logic [DATA_W-1:0] ram [RAM_DEPTH];
    logic              unused_ram_bits;

    // NOTE: the RAM array has no reset; it is storage, not control state,
    // and clearing it would prevent mapping onto a memory macro.
    always_ff @(posedge Clock) begin
        if (RAM_write) ram[mar[RAM_AW-1:0]] <= mdr;
    end

    // Read is combinational so MDR captures RAM[MAR] at the same edge it
    // would have captured Mdatain.
    assign mem_data        = ram[mar[RAM_AW-1:0]];
    assign unused_ram_bits = ^{mar[DATA_W-1:RAM_AW], Mdatain};
`else
    logic unused_ram_bits;

    assign mem_data        = Mdatain;
    assign unused_ram_bits = ^{RAM_write, mar};
`endif

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge bus value, regardless of block ordering.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (R_in) begin
            regs[reg_sel] <= bus;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            pc       <= '0;
            ir       <= '0;
            mar      <= '0;
            mdr      <= '0;
            y_reg    <= '0;
            z_reg    <= '0;
            hi       <= '0;
            lo       <= '0;
            in_port  <= '0;
            out_port <= '0;
            con      <= 1'b0;
        end else begin
            in_port <= InPort_input;
            if (PC_enable)      pc       <= IncPC ? pc + 1'b1 : bus;
            if (IR_enable)      ir       <= bus;
            if (MAR_enable)     mar      <= bus;
            if (MDR_enable)     mdr      <= MDR_read ? mem_data : bus;
            if (Y_enable)       y_reg    <= bus;
            if (HI_enable)      hi       <= bus;
            if (LO_enable)      lo       <= bus;
            if (OutPort_enable) out_port <= bus;
            if (ZLowIn)         z_reg[DATA_W-1:0]        <= alu_result[DATA_W-1:0];
            if (ZHighIn)        z_reg[2*DATA_W-1:DATA_W] <= alu_result[2*DATA_W-1:DATA_W];
            if (CONin)          con      <= con_eval(con_cond_e'(ir[20:19]), bus);
        end
    end

    assign OutPort_output = out_port;

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath
//   Directed self-checking bench for the datapath. Controls are driven 1 ns
//   after the rising edge and results are observed at the same point, after
//   the edge that consumed them.
// -----------------------------------------------------------------------------
module tb_datapath;

    logic        Clock;
    logic        Clear;
    logic [31:0] OutPort_output;
    logic        IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable;
    logic        IR_enable, MDR_read, Gra, Grb, Grc, HI_enable, LO_enable;
    logic        ZHighIn, ZLowIn, Y_enable, PC_enable, OutPort_enable;
    logic        InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout;
    logic        BAout, R_out, Cout, R_in, Cin;
    logic [31:0] InPort_input;
    logic [31:0] Mdatain;

    int tests_run    = 0;
    int tests_failed = 0;

    datapath dut (
        .Clock          (Clock),
        .Clear          (Clear),
        .OutPort_output (OutPort_output),
        .IncPC          (IncPC),
        .CONin          (CONin),
        .RAM_write      (RAM_write),
        .MDR_enable     (MDR_enable),
        .MDRout         (MDRout),
        .MAR_enable     (MAR_enable),
        .IR_enable      (IR_enable),
        .MDR_read       (MDR_read),
        .Gra            (Gra),
        .Grb            (Grb),
        .Grc            (Grc),
        .HI_enable      (HI_enable),
        .LO_enable      (LO_enable),
        .ZHighIn        (ZHighIn),
        .ZLowIn         (ZLowIn),
        .Y_enable       (Y_enable),
        .PC_enable      (PC_enable),
        .OutPort_enable (OutPort_enable),
        .InPortout      (InPortout),
        .PCout          (PCout),
        .Yout           (Yout),
        .ZLowout        (ZLowout),
        .ZHighout       (ZHighout),
        .LOout          (LOout),
        .HIout          (HIout),
        .BAout          (BAout),
        .R_out          (R_out),
        .Cout           (Cout),
        .R_in           (R_in),
        .Cin            (Cin),
        .InPort_input   (InPort_input),
        .Mdatain        (Mdatain)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic clr_ctrl();
        IncPC = 0; CONin = 0; RAM_write = 0; MDR_enable = 0; MDRout = 0;
        MAR_enable = 0; IR_enable = 0; MDR_read = 0; Gra = 0; Grb = 0; Grc = 0;
        HI_enable = 0; LO_enable = 0; ZHighIn = 0; ZLowIn = 0; Y_enable = 0;
        PC_enable = 0; OutPort_enable = 0; InPortout = 0; PCout = 0; Yout = 0;
        ZLowout = 0; ZHighout = 0; LOout = 0; HIout = 0; BAout = 0; R_out = 0;
        Cout = 0; R_in = 0; Cin = 0;
    endtask

    // One clock edge with the currently driven strobes, then release them.
    task automatic step();
        @(posedge Clock);
        #1;
        clr_ctrl();
    endtask

    // The in-port register samples InPort_input on every edge.
    task automatic drive_inport(input logic [31:0] v);
        InPort_input = v;
        step();
    endtask

    task automatic load_ir(input logic [31:0] v);
        drive_inport(v);
        InPortout = 1; IR_enable = 1;
        step();
    endtask

    task automatic load_y(input logic [31:0] v);
        drive_inport(v);
        InPortout = 1; Y_enable = 1;
        step();
    endtask

    // Put b on the bus and capture both halves of the ALU result in Z.
    task automatic alu_z(input logic [31:0] b, input logic c);
        drive_inport(b);
        InPortout = 1; ZLowIn = 1; ZHighIn = 1; Cin = c;
        step();
    endtask

    initial begin
        clr_ctrl();
        Clear        = 1'b1;
        InPort_input = 32'hDEAD_BEEF;
        Mdatain      = 32'h0;
        #2 Clear = 1'b0;
        @(posedge Clock); #1;
        @(posedge Clock); #1;

        // Reset state
        check("rst_pc",    dut.pc,       64'h0);
        check("rst_ir",    dut.ir,       64'h0);
        check("rst_mar",   dut.mar,      64'h0);
        check("rst_mdr",   dut.mdr,      64'h0);
        check("rst_y",     dut.y_reg,    64'h0);
        check("rst_z",     dut.z_reg,    64'h0);
        check("rst_hi",    dut.hi,       64'h0);
        check("rst_lo",    dut.lo,       64'h0);
        check("rst_inp",   dut.in_port,  64'h0);
        check("rst_con",   dut.con,      64'h0);
        check("rst_r15",   dut.regs[15], 64'h0);
        check("rst_out",   OutPort_output, 64'h0);

        Clear = 1'b1;
        PC_enable = 1; IncPC = 1;
        step();
        check("pc_inc", dut.pc, 64'h1);

        // Fetch
        PCout = 1; MAR_enable = 1; ZLowIn = 1; IncPC = 1;
        step();
        check("fetch_mar", dut.mar, 64'h1);
        check("fetch_zlo", dut.z_reg[31:0], 64'h2);
        check("fetch_pc_hold", dut.pc, 64'h1);

        Mdatain = 32'h5908_0002;
        MDR_read = 1; MDR_enable = 1;
        step();
        check("mdr_read", dut.mdr, 64'h5908_0002);

        MDRout = 1; IR_enable = 1;
        step();
        check("ir_load", dut.ir, 64'h5908_0002);

        // Register select: Gra=2, Grb=1, Grc=0, opcode = or
        drive_inport(32'd5);
        InPortout = 1; R_in = 1; Grb = 1;
        step();
        check("r1_load", dut.regs[1], 64'h5);
        check("r2_untouched", dut.regs[2], 64'h0);

        BAout = 1; Grb = 1; Y_enable = 1;
        step();
        check("y_from_r1", dut.y_reg, 64'h5);

        Cout = 1; ZLowIn = 1;
        step();
        check("or_c_sext", dut.z_reg, 64'h7);

        ZLowout = 1; OutPort_enable = 1;
        step();
        check("out_zlo", OutPort_output, 64'h7);

        // R0 reads as zero only through BAout
        drive_inport(32'd9);
        InPortout = 1; R_in = 1; Grc = 1;
        step();
        R_out = 1; Grc = 1; OutPort_enable = 1;
        step();
        check("r0_rout", OutPort_output, 64'h9);
        BAout = 1; Grc = 1; OutPort_enable = 1;
        step();
        check("r0_baout", OutPort_output, 64'h0);

        // CON with IR[20:19] = 01 (nonzero)
        ZLowout = 1; CONin = 1;
        step();
        check("con_nonzero", dut.con, 64'h1);
        CONin = 1;
        step();
        check("con_zero", dut.con, 64'h0);

        // Bus priority
        drive_inport(32'h11);
        InPortout = 1; HI_enable = 1;
        step();
        drive_inport(32'h22);
        InPortout = 1; LO_enable = 1;
        step();
        HIout = 1; LOout = 1; Yout = 1; OutPort_enable = 1;
        step();
        check("prio_hi", OutPort_output, 64'h11);
        LOout = 1; ZLowout = 1; PCout = 1; OutPort_enable = 1;
        step();
        check("prio_lo", OutPort_output, 64'h22);
        R_out = 1; Grb = 1; HIout = 1; OutPort_enable = 1;
        step();
        check("prio_rout", OutPort_output, 64'h5);

        // PC load from bus (in-port still holds 0x22)
        InPortout = 1; PC_enable = 1;
        step();
        check("pc_load", dut.pc, 64'h22);

        // mul / div with Y = -6
        load_ir(32'h7800_0000);
        load_y(32'hFFFF_FFFA);
        alu_z(32'd4, 1'b0);
        check("mul", dut.z_reg, 64'hFFFF_FFFF_FFFF_FFE8);
        ZHighout = 1; OutPort_enable = 1;
        step();
        check("mul_zhi_out", OutPort_output, 64'hFFFF_FFFF);

        load_ir(32'h8000_0000);
        load_y(32'hFFFF_FFFA);
        alu_z(32'd4, 1'b0);
        check("div", dut.z_reg, 64'hFFFF_FFFE_FFFF_FFFF);
        alu_z(32'd0, 1'b0);
        check("div_by_zero", dut.z_reg, 64'hFFFF_FFFA_0000_0000);

        // sub with borrow: 10 - 3 - 1
        load_ir(32'h2000_0000);
        load_y(32'd10);
        alu_z(32'd3, 1'b1);
        check("sub_cin", dut.z_reg, 64'h6);

        // shra: 0x80000010 >>> 4
        load_ir(32'h3000_0000);
        load_y(32'h8000_0010);
        alu_z(32'd4, 1'b0);
        check("shra", dut.z_reg, 64'hFFFF_FFFF_F800_0001);

        // rol: 0x80000001 rotated left 1
        load_ir(32'h4800_0000);
        load_y(32'h8000_0001);
        alu_z(32'd1, 1'b0);
        check("rol", dut.z_reg, 64'h3);

        // not
        load_ir(32'h9000_0000);
        alu_z(32'h0F0F_0F0F, 1'b0);
        check("not", dut.z_reg, 64'hFFFF_FFFF_F0F0_F0F0);

        // IncPC overrides the decoded op
        drive_inport(32'h41);
        IncPC = 1; InPortout = 1; ZLowIn = 1; ZHighIn = 1;
        step();
        check("incpc_override", dut.z_reg, 64'h42);

        // I/O and idle bus
        drive_inport(32'hA5);
        InPortout = 1; OutPort_enable = 1;
        step();
        check("inport_to_out", OutPort_output, 64'hA5);
        Y_enable = 1;
        step();
        check("idle_bus_y", dut.y_reg, 64'h0);

        // Asynchronous reset between edges
        #2 Clear = 1'b0;
        #1;
        check("async_rst_out", OutPort_output, 64'h0);
        check("async_rst_pc",  dut.pc, 64'h0);
        Clear = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit single-bus CPU datapath driven cycle-by-cycle by an external control unit or testbench FSM.
- Contains:
  - register file R0–R15, with IR-field register selection (Gra/Grb/Grc).
  - PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO, in-port and out-port registers, a CON branch flag.
  - an ALU whose operation is decoded from IR[31:27].
- All register-to-register transfers go over one shared 32-bit bus.

Parameters:
- DATA_W, 32, datapath word width.
- RAM_DEPTH, 512, words of internal RAM (used only with the optional feature).

Ports:
- Clock  in  1  system clock; all registers update on its rising edge.
- Clear  in  1  asynchronous active-low reset.
- OutPort_output  out  32  out-port register contents.
- IncPC  in  1  PC increment / ALU "bus+1" override.
- CONin  in  1  load CON flag.
- RAM_write  in  1  write MDR to memory (optional feature).
- MDR_enable  in  1  load MDR.
- MDRout  in  1  MDR drives bus.
- MAR_enable  in  1  load MAR from bus.
- IR_enable  in  1  load IR from bus.
- MDR_read  in  1  MDR source select: 1 = memory data, 0 = bus.
- Gra, Grb, Grc  in  1 each  select register field IR[26:23], IR[22:19], IR[18:15] respectively.
- HI_enable, LO_enable  in  1 each  load HI / LO from bus.
- ZHighIn, ZLowIn  in  1 each  load Z[63:32] / Z[31:0] from ALU result.
- Y_enable  in  1  load Y from bus.
- PC_enable  in  1  load or increment PC.
- OutPort_enable  in  1  load out-port from bus.
- InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, MDRout  in  1 each  named register drives bus.
- BAout  in  1  selected register drives bus; R0 reads as 0.
- R_out  in  1  selected register drives bus.
- Cout  in  1  sign-extended IR[18:0] drives bus.
- R_in  in  1  load selected register from bus.
- Cin  in  1  carry-in for add/sub.
- InPort_input  in  32  external input port data.
- Mdatain  in  32  memory read data.

Behaviour:
- Reset (Clear=0, asynchronous):
  - Every register is cleared: R0–R15, PC, IR, MAR, MDR, Y, Z, HI, LO, in-port, out-port, CON.
  - OutPort_output = 0.
- Register selection:
  - The selected index is the OR-combination of the fields whose Gr* strobe is high; normally exactly one is high.
  - R_in writes R[idx] ← bus at the clock edge.
  - R_out drives R[idx]. BAout drives R[idx], or 0 when idx = 0.
- Bus driver priority when several *out strobes are high, highest first:
  - R_out/BAout, HIout, LOout, ZHighout, ZLowout, PCout, MDRout, InPortout, Yout, Cout.
  - No strobe high → bus = 0.
- PC update:
  - PC_enable & IncPC → PC ← PC+1.
  - PC_enable & !IncPC → PC ← bus.
- MDR: MDR_enable → MDR ← (MDR_read ? Mdatain : bus).
- In-port register: loads InPort_input on every edge.
- ALU operands: A = Y, B = bus. Result is 64-bit, loaded into Z halves by ZLowIn/ZHighIn.
- ALU operation:
  - IncPC=1 overrides decode: result = B+1.
  - Otherwise by IR[31:27]:
    - ld/ldi/st/add/addi/jal (00000–00011, 01100, 10101): A+B+Cin.
    - sub (00100): A−B−Cin.
    - shr (00101): logical right, shift amount B[4:0]. shra (00110): arithmetic right. shl (00111): left.
    - ror (01000) / rol (01001): rotate by B[4:0].
    - and/andi (01010, 01101): A&B. or/ori (01011, 01110): A|B.
    - mul (01111): signed A×B, full 64 bits.
    - div (10000): Z[31:0] = signed A/B, Z[63:32] = remainder. B = 0 gives quotient 0 and remainder A.
    - neg (10001): −B. not (10010): ~B.
    - any other code: B (pass-through).
  - Upper Z half is sign-extension for all ops except mul and div.
- CON flag: CONin → CON ← condition IR[20:19] evaluated on the bus value:
  - 00: zero
  - 01: nonzero
  - 10: ≥0 (signed)
  - 11: <0 (signed)
- Simultaneous loads: all enabled registers capture the same bus value in the same edge.

Optional Feature:
- DATAPATH_INTERNAL_RAM_EN defined:
  - Adds a RAM_DEPTH×32 synchronous RAM addressed by MAR[8:0].
  - RAM_write → RAM[MAR] ← MDR.
  - MDR_read selects RAM[MAR] instead of Mdatain; Mdatain is ignored.
  - RAM content is not cleared by reset.
- Undefined:
  - No RAM; RAM_write is ignored.
  - MDR_read selects Mdatain.

Decomposition:
- Package datapath_pkg holds:
  - the opcode constants, 5-bit, listed above.
  - the CON condition encodings.
  - DATA_W.
- One sub-module, datapath_alu, is purely combinational: inputs A, B, opcode, IncPC, Cin; output 64-bit result.

Test Plan:
- Reset: with Clear=0, all registers = 0 and OutPort_output = 0. Release Clear, then PC_enable+IncPC for one edge → PC = 1.
- Fetch:
  - PCout+MAR_enable+ZLowIn with IncPC=1 → MAR = 1, Z[31:0] = 2.
  - Mdatain=0x59080002 with MDR_read+MDR_enable → MDR = 0x59080002.
  - MDRout+IR_enable → IR = 0x59080002.
- Register select with IR=0x59080002 (Gra field = 2, Grb field = 1):
  - Load R1=5 via R_in+Grb.
  - BAout+Grb then Y_enable → Y = 5.
  - Cout → bus = 2; ZLowIn → Z = 0x7 (opcode 01011, or).
- mul/div:
  - Y = −6, bus = 4: mul → Z = 0xFFFFFFFF_FFFFFFE8.
  - div → Z[31:0] = 0xFFFFFFFF (−1), Z[63:32] = −2.
  - bus = 0 → quotient 0, remainder −6.
- CON with IR[20:19]=01:
  - bus = 0 → CON = 0.
  - bus = 7 → CON = 1.
- I/O and bus:
  - InPort_input = 0xA5 → InPortout+OutPort_enable → OutPort_output = 0xA5.
  - No out strobes asserted → Y_enable loads 0.
